// File: rtl/dec_pkg.sv
// Shared types and helpers for the registered N-to-2^N decoder.
// Build option DECODER_ACTIVE_LOW_EN lives in decoder_scan_n; nothing here depends on it.
package dec_pkg;

    localparam int DEF_IN_W = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DIRECT = 2'd1;
    localparam state_t ST_SCAN   = 2'd2;

    // Widest legal decode is 6 -> 64 lines; callers truncate to their own width.
    function automatic logic [63:0] onehot(input logic [5:0] code);
        return 64'd1 << code;
    endfunction

endpackage

// File: rtl/scan_divider.sv
// Free-running divider for the scan mode: tick marks the terminal count 0..SCAN_DIV-1.
// clr holds the count at zero and suppresses tick.
module scan_divider #(
    parameter int SCAN_DIV = 50_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == TC) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with direct (valid-qualified) and auto-scan modes.
// Define DECODER_ACTIVE_LOW_EN to drive out inverted (74HC138 style, idle = all ones).
module decoder_scan_n
    import dec_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int SCAN_DIV = 50_000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_code,
    output logic [(1<<IN_W)-1:0]   out,
    output logic                   out_valid,
    output logic [IN_W-1:0]        scan_idx,
    output logic                   scan_tick
);

    // state  | meaning
    // IDLE   | disabled; outputs cleared, scan position forgotten
    // DIRECT | decode in_code on each in_valid, hold otherwise
    // SCAN   | step the active line every SCAN_DIV cycles, wrapping

    localparam int OUT_W = 2 ** IN_W;

    state_t            state_q, state_d;
    logic [OUT_W-1:0]  oh_q, oh_d;
    logic              vld_q, vld_d;
    logic [IN_W-1:0]   idx_q, idx_d;
    logic              tick_q, tick_d;
    logic              div_clr;
    logic              advance;

    always_comb begin
        if (!en)       state_d = ST_IDLE;
        else if (mode) state_d = ST_SCAN;
        else           state_d = ST_DIRECT;
    end

    // Divider only runs while staying in SCAN, so every entry restarts it from 0.
    assign div_clr = !((state_q == ST_SCAN) && (state_d == ST_SCAN));

    scan_divider #(.SCAN_DIV(SCAN_DIV)) u_div (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (div_clr),
        .tick      (advance)
    );

    always_comb begin
        oh_d   = oh_q;
        vld_d  = 1'b0;
        idx_d  = idx_q;
        tick_d = 1'b0;
        case (state_d)
            ST_DIRECT: begin
                idx_d = '0;
                // A valid on the entry edge is decoded rather than cleared.
                if (in_valid) begin
                    oh_d  = OUT_W'(onehot(6'(in_code)));
                    vld_d = 1'b1;
                end else if (state_q != ST_DIRECT) begin
                    oh_d = '0;
                end
            end
            ST_SCAN: begin
                if (state_q != ST_SCAN) begin
                    idx_d = '0;
                    oh_d  = OUT_W'(1);
                end else if (advance) begin
                    idx_d  = idx_q + 1'b1;
                    oh_d   = OUT_W'(onehot(6'(idx_d)));
                    tick_d = 1'b1;
                end
            end
            default: begin
                oh_d  = '0;
                idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            oh_q    <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            oh_q    <= oh_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
        end
    end

`ifdef DECODER_ACTIVE_LOW_EN
    assign out = ~oh_q;
`else
    assign out = oh_q;
`endif
    assign out_valid = vld_q;
    assign scan_idx  = idx_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Bench for decoder_scan_n: direct-mode vector table plus scan, reset and enable sequences.
// Honours DECODER_ACTIVE_LOW_EN by inverting the expected out value.
module tb_decoder_scan_n;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n, en, mode, in_valid;
    logic [2:0] in_code;
    logic [7:0] out4, out1;
    logic       vld4, vld1, tick4, tick1;
    logic [2:0] idx4, idx1;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    decoder_scan_n #(.IN_W(3), .SCAN_DIV(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_code(in_code), .out(out4), .out_valid(vld4),
        .scan_idx(idx4), .scan_tick(tick4)
    );

    decoder_scan_n #(.IN_W(3), .SCAN_DIV(1)) dut_div1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_code(in_code), .out(out1), .out_valid(vld1),
        .scan_idx(idx1), .scan_tick(tick1)
    );

    typedef struct {
        logic [7:0] o;
        logic       v;
        logic [2:0] idx;
        logic       tk;
        bit         chk1;
        logic [7:0] o1;
        logic [2:0] idx1;
        logic       tk1;
    } exp_t;

    typedef struct {
        logic       en, mode, vld;
        logic [2:0] code;
        logic [7:0] o;
        logic       v;
    } vec_t;

    exp_t sb[$];

    function automatic logic [7:0] phys(input logic [7:0] x);
`ifdef DECODER_ACTIVE_LOW_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    function automatic exp_t mk(input logic [7:0] o, input logic v, input logic [2:0] idx,
                                input logic tk);
        exp_t e;
        e.o = o; e.v = v; e.idx = idx; e.tk = tk;
        e.chk1 = 1'b0; e.o1 = '0; e.idx1 = '0; e.tk1 = 1'b0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare #1 after the edge.
    task automatic step(input logic rn, input logic e, input logic m, input logic v,
                        input logic [2:0] c, input exp_t x, input string nm);
        exp_t got_exp;
        sys_rst_n = rn; en = e; mode = m; in_valid = v; in_code = c;
        sb.push_back(x);
        @(posedge sys_clk);
        #1;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            got_exp = sb.pop_front();
            chk({nm, "_out"},  64'(out4),  64'(phys(got_exp.o)));
            chk({nm, "_vld"},  64'(vld4),  64'(got_exp.v));
            chk({nm, "_idx"},  64'(idx4),  64'(got_exp.idx));
            chk({nm, "_tick"}, 64'(tick4), 64'(got_exp.tk));
            if (got_exp.chk1) begin
                chk({nm, "_d1_out"},  64'(out1),  64'(phys(got_exp.o1)));
                chk({nm, "_d1_idx"},  64'(idx1),  64'(got_exp.idx1));
                chk({nm, "_d1_tick"}, 64'(tick1), 64'(got_exp.tk1));
                chk({nm, "_d1_vld"},  64'(vld1),  64'd0);
            end
        end
    endtask

    vec_t vecs[$];

    initial begin
        exp_t x;
        sys_rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; in_code = '0;

        // {en, mode, vld, code, expected out (active-high), expected out_valid}
        vecs.push_back('{1, 0, 1, 3'd5, 8'h20, 1});
        vecs.push_back('{1, 0, 0, 3'd1, 8'h20, 0});
        vecs.push_back('{1, 0, 0, 3'd6, 8'h20, 0});
        vecs.push_back('{1, 0, 1, 3'd0, 8'h01, 1});
        vecs.push_back('{1, 0, 1, 3'd1, 8'h02, 1});
        vecs.push_back('{1, 0, 1, 3'd2, 8'h04, 1});
        vecs.push_back('{1, 0, 1, 3'd3, 8'h08, 1});
        vecs.push_back('{1, 0, 1, 3'd4, 8'h10, 1});
        vecs.push_back('{1, 0, 1, 3'd5, 8'h20, 1});
        vecs.push_back('{1, 0, 1, 3'd6, 8'h40, 1});
        vecs.push_back('{1, 0, 1, 3'd7, 8'h80, 1});
        vecs.push_back('{1, 0, 0, 3'd2, 8'h80, 0});
        vecs.push_back('{0, 0, 1, 3'd3, 8'h00, 0});   // en low beats in_valid
        vecs.push_back('{1, 0, 0, 3'd3, 8'h00, 0});   // DIRECT entry without valid
        vecs.push_back('{1, 0, 1, 3'd2, 8'h04, 1});
        vecs.push_back('{1, 1, 1, 3'd3, 8'h01, 0});   // SCAN entry ignores in_valid
        vecs.push_back('{1, 0, 0, 3'd3, 8'h00, 0});   // leaving SCAN clears out

        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, mk(8'h00, 0, 3'd0, 0), "reset0");
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, mk(8'h00, 0, 3'd0, 0), "reset1");

        for (int i = 0; i < vecs.size(); i++)
            step(1'b1, vecs[i].en, vecs[i].mode, vecs[i].vld, vecs[i].code,
                 mk(vecs[i].o, vecs[i].v, 3'd0, 1'b0), $sformatf("vec%0d", i));

        // Scan run: one step per 4 cycles on dut, every cycle on dut_div1.
        for (int k = 0; k < 58; k++) begin
            x = mk(8'd1 << ((k / 4) % 8), 1'b0, 3'((k / 4) % 8), (k > 0) && (k % 4 == 0));
            x.chk1 = 1'b1;
            x.o1   = 8'd1 << (k % 8);
            x.idx1 = 3'(k % 8);
            x.tk1  = (k > 0);
            step(1'b1, 1'b1, 1'b1, k[0], 3'(k), x, $sformatf("scan%0d", k));
        end

        // Reset while dut sits at index 6.
        x = mk(8'h00, 0, 3'd0, 0);
        x.chk1 = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, x, "midscan_rst");

        for (int k = 0; k < 6; k++) begin
            x = mk(8'd1 << (k / 4), 1'b0, 3'(k / 4), (k > 0) && (k % 4 == 0));
            x.chk1 = 1'b1;
            x.o1   = 8'd1 << k;
            x.idx1 = 3'(k);
            x.tk1  = (k > 0);
            step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, x, $sformatf("rescan%0d", k));
        end

        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, mk(8'h00, 0, 3'd0, 0), "en_drop");
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, mk(8'h01, 0, 3'd0, 0), "reenable0");
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, mk(8'h01, 0, 3'd0, 0), "reenable1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
